fir_ctrl: RTL and testbench
===========================

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the completed-sample counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  upstream has a new sample on the datapath input.
REQ-005 in_ready  output  1  controller can accept a sample this cycle.
REQ-006 out_valid  output  1  the datapath output register holds a finished result.
REQ-007 out_ready  input  1  downstream accepts the result.
REQ-008 flush  input  1  request to zero the tap delay line; used only when FIR_CTRL_FLUSH_EN is defined.
REQ-009 ld_x  output  1  load enable for the datapath input sample register.
REQ-010 clr_acc  output  1  synchronous clear of the datapath accumulator.
REQ-011 ld_acc  output  1  accumulate enable: acc <= acc + coef[mac_sel] * tap[mac_sel].
REQ-012 mac_sel  output  2  selects tap 0/1/2 for the shared multiplier; value 3 is never driven.
REQ-013 ld_delay  output  1  common load enable for delay1 and delay2; shifts the delay line one place.
REQ-014 clr_taps  output  1  synchronous clear of the input and delay registers.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 sample_cnt  output  CNT_WIDTH  count of completed output handshakes.

Function
REQ-017 The FSM shall have the states IDLE, MAC0, MAC1, MAC2, OUT and FLUSH, encoded in one registered state vector.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, ld_x=1 and clr_acc=1 combinationally in that same cycle, next state MAC0.
REQ-019 MAC0/MAC1/MAC2: ld_acc=1, mac_sel=0/1/2 respectively, in_ready=0, one cycle each, unconditional advance to OUT after MAC2.
REQ-020 OUT: out_valid=1 held until out_ready; on out_valid&out_ready, ld_delay=1 in that cycle, sample_cnt increments, next state IDLE.
REQ-021 Latency: input accept in cycle N gives out_valid high from cycle N+4; with out_ready held at 1 the throughput is one sample per 5 cycles.
REQ-022 ld_x, clr_acc, ld_acc, ld_delay and clr_taps shall each be asserted only in the states and cycles listed above, and 0 everywhere else.
REQ-023 in_valid in non-IDLE states shall be ignored and not queued; upstream holds it.
REQ-024 Backpressure: while in OUT with out_ready=0, all load enables shall stay 0 and the delay line shall remain unchanged.
REQ-025 sample_cnt shall wrap from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-026 mac_sel shall be 0 in every state other than MAC1 and MAC2.

Reset
REQ-027 Asserting rst shall force IDLE, sample_cnt=0 and all enables to 0, immediately and independent of clk.
REQ-028 Outputs during and after reset: in_ready=1, out_valid=0, busy=0, mac_sel=0.
REQ-029 rst mid-sequence (in MAC0..OUT) shall abandon the result with no out_valid pulse; the datapath registers are reset by their own rst.

Configuration
REQ-030 Macro FIR_CTRL_FLUSH_EN defined: flush=1 in IDLE shall go to FLUSH. flush takes priority over a simultaneous in_valid, and in_ready=0 in that cycle. FLUSH: clr_taps=1 for exactly one cycle, then IDLE. sample_cnt is unchanged. flush outside IDLE is ignored.
REQ-031 Macro not defined: the flush port exists but is ignored, the FLUSH state is not synthesised, and clr_taps is tied to 0.

Verification
REQ-032 Reset, then in_valid=1 for one cycle at cycle 0 with out_ready=1 -> ld_x/clr_acc at cycle 0; mac_sel 0,1,2 with ld_acc at cycles 1-3; out_valid and ld_delay at cycle 4; sample_cnt=1.
REQ-033 Streaming: in_valid and out_ready held high for 10 samples -> 50 cycles, sample_cnt=10, in_ready high every 5th cycle.
REQ-034 Backpressure: out_ready=0 for 7 cycles in OUT -> out_valid stays high, ld_delay=0 throughout; ld_delay pulses once on the cycle out_ready rises.
REQ-035 Wrap: CNT_WIDTH=4, 17 samples -> sample_cnt reads 15, then 0, then 1.
REQ-036 With FIR_CTRL_FLUSH_EN: flush and in_valid high together in IDLE -> clr_taps=1 for one cycle, no ld_x, sample accepted the following cycle. Without the macro: same stimulus -> clr_taps=0 and the sample is accepted immediately.
REQ-037 rst pulsed during MAC1 -> state IDLE and out_valid=0 at once; no ld_delay pulse occurs.

Source files
------------

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencer for a 3-tap FIR datapath with one shared multiplier.
// Optional flush of the tap delay line is enabled by defining FIR_CTRL_FLUSH_EN.
`default_nettype none

module fir_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 ld_x,
    output logic                 clr_acc,
    output logic                 ld_acc,
    output logic [1:0]           mac_sel,
    output logic                 ld_delay,
    output logic                 clr_taps,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC0  = 3'd1,
        S_MAC1  = 3'd2,
        S_MAC2  = 3'd3,
        S_OUT   = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   flush_req;

`ifdef FIR_CTRL_FLUSH_EN
    assign flush_req = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_req    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ld_x      = 1'b0;
        clr_acc   = 1'b0;
        ld_acc    = 1'b0;
        mac_sel   = 2'd0;
        ld_delay  = 1'b0;
        clr_taps  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // IDLE enables are input-driven, so they are masked while rst is high
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid && !rst) begin
                        ld_x    = 1'b1;
                        clr_acc = 1'b1;
                        state_d = S_MAC0;
                    end
                end
            end
            S_MAC0: begin
                ld_acc  = 1'b1;
                mac_sel = 2'd0;
                state_d = S_MAC1;
            end
            S_MAC1: begin
                ld_acc  = 1'b1;
                mac_sel = 2'd1;
                state_d = S_MAC2;
            end
            S_MAC2: begin
                ld_acc  = 1'b1;
                mac_sel = 2'd2;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ld_delay = 1'b1;
                    cnt_d    = cnt_q + CNT_WIDTH'(1);
                    state_d  = S_IDLE;
                end
            end
`ifdef FIR_CTRL_FLUSH_EN
            S_FLUSH: begin
                clr_taps = 1'b1;
                state_d  = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign sample_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl: vector table plus directed multi-cycle sequences.
`default_nettype none

module tb_fir_ctrl;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, flush;
    logic in_ready, out_valid, ld_x, clr_acc, ld_acc, ld_delay, clr_taps, busy;
    logic [1:0]  mac_sel;
    logic [15:0] sample_cnt;

    logic in_ready4, out_valid4, ld_x4, clr_acc4, ld_acc4, ld_delay4, clr_taps4, busy4;
    logic [1:0]  mac_sel4;
    logic [3:0]  sample_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .ld_x(ld_x), .clr_acc(clr_acc), .ld_acc(ld_acc), .mac_sel(mac_sel),
        .ld_delay(ld_delay), .clr_taps(clr_taps), .busy(busy), .sample_cnt(sample_cnt)
    );

    fir_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready), .flush(flush),
        .ld_x(ld_x4), .clr_acc(clr_acc4), .ld_acc(ld_acc4), .mac_sel(mac_sel4),
        .ld_delay(ld_delay4), .clr_taps(clr_taps4), .busy(busy4), .sample_cnt(sample_cnt4)
    );

    // {in_ready, out_valid, ld_x, clr_acc, ld_acc, mac_sel[1:0], ld_delay, clr_taps, busy}
    logic [9:0] outs;
    assign outs = {in_ready, out_valid, ld_x, clr_acc, ld_acc, mac_sel, ld_delay, clr_taps, busy};

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [9:0] exp;
        int         cnt;
    } vec_t;

    vec_t tbl [19];

    localparam logic [9:0] E_IDLE   = 10'b1_0_0_0_0_00_0_0_0;
    localparam logic [9:0] E_ACCEPT = 10'b1_0_1_1_0_00_0_0_0;
    localparam logic [9:0] E_MAC0   = 10'b0_0_0_0_1_00_0_0_1;
    localparam logic [9:0] E_MAC1   = 10'b0_0_0_0_1_01_0_0_1;
    localparam logic [9:0] E_MAC2   = 10'b0_0_0_0_1_10_0_0_1;
    localparam logic [9:0] E_OUTW   = 10'b0_1_0_0_0_00_0_0_1;
    localparam logic [9:0] E_OUTGO  = 10'b0_1_0_0_0_00_1_0_1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // one sample through with out_ready high, starting in IDLE
    task automatic one_sample();
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        repeat (4) next_cycle();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, E_ACCEPT, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, E_MAC0,   0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, E_MAC1,   0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, E_MAC2,   0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, E_OUTGO,  0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, E_IDLE,   1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, E_ACCEPT, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, E_MAC0,   1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, E_MAC1,   1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, E_MAC2,   1};
        for (int i = 10; i < 17; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, E_OUTW, 1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, E_OUTGO,  1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, E_IDLE,   2};

        // reset state, with in_valid high to confirm enables are masked
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'(outs), 32'(E_IDLE));
        chk("reset_cnt", 32'(sample_cnt), 0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_cnt", i), 32'(sample_cnt), 32'(tbl[i].cnt));
            next_cycle();
        end

        // streaming: 10 samples in 50 cycles
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'((i % 5) == 0));
            chk($sformatf("stream%0d_ld_delay", i), 32'(ld_delay), 32'((i % 5) == 4));
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_cnt", 32'(sample_cnt), 12);
        chk("stream_idle", 32'(outs), 32'(E_IDLE));
        next_cycle();

        // counter wrap on the 4-bit instance
        for (int k = 13; k <= 17; k++) begin
            one_sample();
            chk($sformatf("wrap_cnt4_%0d", k), 32'(sample_cnt4), 32'(k % 16));
            chk($sformatf("wrap_cnt16_%0d", k), 32'(sample_cnt), 32'(k));
        end

        // flush with simultaneous in_valid in IDLE
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
`ifdef FIR_CTRL_FLUSH_EN
        @(negedge clk);
        chk("flush_req_outs", 32'(outs), 32'(10'b0_0_0_0_0_00_0_0_0));
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_state_outs", 32'(outs), 32'(10'b0_0_0_0_0_00_0_1_1));
        next_cycle();
        @(negedge clk);
        chk("flush_then_accept", 32'(outs), 32'(E_ACCEPT));
        next_cycle();
`else
        @(negedge clk);
        chk("noflush_accept", 32'(outs), 32'(E_ACCEPT));
        next_cycle();
`endif
        // flush during MAC must be ignored
        in_valid = 1'b0; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("flush_mac%0d_clr_taps", i), 32'(clr_taps), 0);
            chk($sformatf("flush_mac%0d_sel", i), 32'(mac_sel), 32'(i));
            next_cycle();
        end
        flush = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("flush_cnt", 32'(sample_cnt), 18);
        chk("flush_cnt4", 32'(sample_cnt4), 2);

        // asynchronous reset during MAC1
        next_cycle();
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("pre_rst_mac1", 32'(outs), 32'(E_MAC1));
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 32'(outs), 32'(E_IDLE));
        chk("rst_mid_cnt", 32'(sample_cnt), 0);
        next_cycle();
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_out_valid", i), 32'(out_valid), 0);
            chk($sformatf("post_rst%0d_ld_delay", i), 32'(ld_delay), 0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
